// File: rtl/cal_pulse_gen.sv
// -----------------------------------------------------------------------------
// cal_pulse_gen
// Programmable calibration pulse train generator for the NMR front end.
// It sits between the host/sequencer register interface and the calibration
// injection circuitry. It produces a train of pulses with a programmable
// period P and high time H. The train runs either as a fixed burst of B
// periods or continuously until a graceful stop request is honoured.
//
// Parameters:
//   DIV_W : width of the period / high-time fields (period up to 2^DIV_W)
//   CNT_W : width of the burst length and the completed-period counter
//
// Ports:
//   cal_clkin     in   clock, all logic on the rising edge
//   cal_reset     in   asynchronous active-low reset
//   cal_en        in   count enable; low freezes all run state
//   cal_load      in   latch the configuration into the shadow registers;
//                      aborts any run
//   cal_divcount  in   period minus one
//   cal_highcount in   high cycles per period
//   cal_burst     in   periods per burst, 0 = continuous
//   cal_start     in   start a run (level sampled)
//   cal_stop      in   request a stop at the end of the current period
//   cal_out       out  calibration pulse (registered)
//   cal_busy      out  high while running
//   cal_done      out  one-cycle pulse when a run ends normally
//   cal_pcount    out  completed periods in the current or last run
// -----------------------------------------------------------------------------
module cal_pulse_gen #(
    parameter int DIV_W = 10,
    parameter int CNT_W = 8
) (
    input  logic             cal_clkin,
    input  logic             cal_reset,
    input  logic             cal_en,
    input  logic             cal_load,
    input  logic [DIV_W-1:0] cal_divcount,
    input  logic [DIV_W-1:0] cal_highcount,
    input  logic [CNT_W-1:0] cal_burst,
    input  logic             cal_start,
    input  logic             cal_stop,
    output logic             cal_out,
    output logic             cal_busy,
    output logic             cal_done,
    output logic [CNT_W-1:0] cal_pcount
);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_RUN  = 1'b1;

    localparam logic [DIV_W-1:0] C_DIV_ZERO = {DIV_W{1'b0}};
    localparam logic [DIV_W-1:0] C_DIV_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};
    localparam logic [DIV_W:0]   C_P_ONE    = {{DIV_W{1'b0}}, 1'b1};
    localparam logic [DIV_W:0]   C_P_RESET  = {{(DIV_W-1){1'b0}}, 2'b10};
    localparam logic [CNT_W-1:0] C_CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] C_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] C_CNT_MAX  = {CNT_W{1'b1}};

    // Shadow configuration and run state
    logic             r_state;
    logic [DIV_W:0]   r_p;        // period, one bit wider so 2^DIV_W fits
    logic [DIV_W-1:0] r_h;        // high time, always within [1, P-1]
    logic [CNT_W-1:0] r_b;        // burst length, 0 = continuous
    logic [DIV_W-1:0] r_phase;
    logic             r_stop_req;
    logic             r_out;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_pcount;

    logic [DIV_W-1:0] w_div_eff;
    logic [DIV_W:0]   w_p_new;
    logic [DIV_W-1:0] w_h_new;
    logic [DIV_W-1:0] w_phase_next;
    logic             w_wrap;
    logic [CNT_W-1:0] w_pcount_inc;
    logic             w_burst_end;
    logic             w_run_end;

    // Configuration arithmetic applied on load: P = max(div,1)+1, H clamped to [1, P-1]
    always_comb begin
        w_div_eff = cal_divcount;
        w_h_new   = cal_highcount;
        if (cal_divcount == C_DIV_ZERO) begin
            w_div_eff = C_DIV_ONE;
        end else begin
            w_div_eff = cal_divcount;
        end
        w_p_new = {1'b0, w_div_eff} + C_P_ONE;
        // P-1 equals w_div_eff, which is why the upper clamp uses it directly
        if (cal_highcount == C_DIV_ZERO) begin
            w_h_new = C_DIV_ONE;
        end else if (cal_highcount > w_div_eff) begin
            w_h_new = w_div_eff;
        end else begin
            w_h_new = cal_highcount;
        end
    end

    // Period wrap detection, saturating period count and run-end decision
    always_comb begin
        w_phase_next = r_phase + C_DIV_ONE;
        w_wrap       = ({1'b0, r_phase} == (r_p - C_P_ONE));
        if (r_pcount == C_CNT_MAX) begin
            w_pcount_inc = r_pcount;
        end else begin
            w_pcount_inc = r_pcount + C_CNT_ONE;
        end
        w_burst_end = (r_b != C_CNT_ZERO) && (w_pcount_inc == r_b);
        // A stop sampled on the wrap edge itself ends the run on that wrap
        w_run_end   = w_burst_end || r_stop_req || cal_stop;
    end

    // Main sequencer: load has top priority, then start / run / wrap handling
    always_ff @(posedge cal_clkin or negedge cal_reset) begin
        if (!cal_reset) begin
            r_state    <= ST_IDLE;
            r_p        <= C_P_RESET;
            r_h        <= C_DIV_ONE;
            r_b        <= C_CNT_ZERO;
            r_phase    <= C_DIV_ZERO;
            r_stop_req <= 1'b0;
            r_out      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pcount   <= C_CNT_ZERO;
        end else begin
            r_done <= 1'b0;
            if (cal_load) begin
                r_p        <= w_p_new;
                r_h        <= w_h_new;
                r_b        <= cal_burst;
                r_phase    <= C_DIV_ZERO;
                r_stop_req <= 1'b0;
                r_state    <= ST_IDLE;
                r_out      <= 1'b0;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (cal_start && cal_en) begin
                            r_state    <= ST_RUN;
                            r_phase    <= C_DIV_ZERO;
                            r_pcount   <= C_CNT_ZERO;
                            r_stop_req <= 1'b0;
                            r_out      <= 1'b1;
                            r_busy     <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    ST_RUN: begin
                        if (cal_en) begin
                            if (w_wrap) begin
                                r_pcount <= w_pcount_inc;
                                r_phase  <= C_DIV_ZERO;
                                if (w_run_end) begin
                                    r_state    <= ST_IDLE;
                                    r_out      <= 1'b0;
                                    r_busy     <= 1'b0;
                                    r_done     <= 1'b1;
                                    r_stop_req <= 1'b0;
                                end else begin
                                    r_out <= 1'b1;
                                end
                            end else begin
                                r_phase    <= w_phase_next;
                                r_out      <= (w_phase_next < r_h);
                                r_stop_req <= r_stop_req | cal_stop;
                            end
                        end else begin
                            // Frozen: only the stop request may still be latched
                            r_stop_req <= r_stop_req | cal_stop;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_out   <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cal_out    = r_out;
    assign cal_busy   = r_busy;
    assign cal_done   = r_done;
    assign cal_pcount = r_pcount;

endmodule

// File: tb/tb_cal_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_cal_pulse_gen
// Scoreboard bench for cal_pulse_gen. The driver applies inputs on the falling
// edge and pushes the reference model's expected outputs for the next rising
// edge into a queue. The monitor pops the queue shortly after each rising edge
// and compares. The reference model tracks the number of enabled cycles since
// the start of a run and derives phase and period count arithmetically.
// -----------------------------------------------------------------------------
module tb_cal_pulse_gen;

    localparam int DIV_W   = 10;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             ld;
    logic [DIV_W-1:0] divc;
    logic [DIV_W-1:0] highc;
    logic [CNT_W-1:0] burst;
    logic             start;
    logic             stop;
    logic             out_s;
    logic             busy_s;
    logic             done_s;
    logic [CNT_W-1:0] pcount_s;

    cal_pulse_gen #(.DIV_W(DIV_W), .CNT_W(CNT_W)) dut (
        .cal_clkin     (clk),
        .cal_reset     (rst_n),
        .cal_en        (en),
        .cal_load      (ld),
        .cal_divcount  (divc),
        .cal_highcount (highc),
        .cal_burst     (burst),
        .cal_start     (start),
        .cal_stop      (stop),
        .cal_out       (out_s),
        .cal_busy      (busy_s),
        .cal_done      (done_s),
        .cal_pcount    (pcount_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       out;
        logic       busy;
        logic       done;
        logic [7:0] pc;
    } exp_t;

    exp_t exp_q[$];

    int n_cmp  = 0;
    int n_fail = 0;
    int n_done_seen = 0;

    // Reference model state
    int m_p, m_h, m_b, m_t, m_pc;
    bit m_run, m_stop, m_out;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, expv);
        end
    endtask

    task automatic model_reset();
        m_p = 2; m_h = 1; m_b = 0; m_t = 0; m_pc = 0;
        m_run = 0; m_stop = 0; m_out = 0;
    endtask

    // Expected outputs after the coming rising edge, from the current inputs
    task automatic model_edge();
        exp_t e;
        e.done = 1'b0;
        if (ld) begin
            m_p    = ((int'(divc) < 1) ? 1 : int'(divc)) + 1;
            m_h    = (int'(highc) < 1) ? 1 : ((int'(highc) > m_p - 1) ? m_p - 1 : int'(highc));
            m_b    = int'(burst);
            m_run  = 0;
            m_out  = 0;
            m_stop = 0;
        end else if (!m_run) begin
            if (start && en) begin
                m_run = 1; m_t = 0; m_pc = 0; m_stop = 0; m_out = 1;
            end
        end else begin
            if (stop) m_stop = 1;
            if (en) begin
                m_t++;
                if (m_t % m_p == 0) begin
                    m_pc = (m_t / m_p > CNT_MAX) ? CNT_MAX : m_t / m_p;
                    if ((m_b != 0 && m_pc == m_b) || m_stop) begin
                        m_run = 0; m_out = 0; m_stop = 0; e.done = 1'b1;
                    end else begin
                        m_out = 1;
                    end
                end else begin
                    m_out = ((m_t % m_p) < m_h);
                end
            end
        end
        e.out  = m_out;
        e.busy = m_run;
        e.pc   = 8'(m_pc);
        exp_q.push_back(e);
    endtask

    // One cycle of stimulus: drive on the falling edge, predict the next rise
    task automatic step(input bit l, input bit s, input bit sp, input bit e_n);
        @(negedge clk);
        ld = l; start = s; stop = sp; en = e_n;
        model_edge();
    endtask

    task automatic load_cfg(input int dv, input int hc, input int bu);
        divc = DIV_W'(dv); highc = DIV_W'(hc); burst = CNT_W'(bu);
        step(1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic async_reset();
        @(negedge clk);
        ld = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_out",  32'(out_s),    32'd0);
        chk("async_rst_busy", 32'(busy_s),   32'd0);
        chk("async_rst_done", 32'(done_s),   32'd0);
        chk("async_rst_pcnt", 32'(pcount_s), 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Monitor: compare the DUT against the oldest queued expectation
    always begin
        exp_t e;
        @(posedge clk);
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out",    32'(out_s),    32'(e.out));
            chk("busy",   32'(busy_s),   32'(e.busy));
            chk("done",   32'(done_s),   32'(e.done));
            chk("pcount", 32'(pcount_s), 32'(e.pc));
            if (e.done) n_done_seen++;
        end
    end

    initial begin
        rst_n = 1'b0; en = 1'b1; ld = 1'b0; start = 1'b0; stop = 1'b0;
        divc = '0; highc = '0; burst = '0;
        model_reset();
        #7;
        chk("reset_out",  32'(out_s),    32'd0);
        chk("reset_busy", 32'(busy_s),   32'd0);
        chk("reset_done", 32'(done_s),   32'd0);
        chk("reset_pcnt", 32'(pcount_s), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Default shadow config after reset: P=2, H=1, continuous
        step(1'b0, 1'b1, 1'b0, 1'b1); idle(5);
        step(1'b0, 1'b0, 1'b1, 1'b1); idle(4);

        // Burst of 3 periods, 1,1,0,0,0 pattern
        load_cfg(4, 2, 3);
        step(1'b0, 1'b1, 1'b0, 1'b1); idle(20);

        // Clamping cases
        load_cfg(0, 0, 0);
        step(1'b0, 1'b1, 1'b0, 1'b1); idle(6);
        step(1'b0, 1'b0, 1'b1, 1'b1); idle(4);
        load_cfg(3, 9, 0);
        step(1'b0, 1'b1, 1'b0, 1'b1); idle(8);
        step(1'b0, 1'b0, 1'b1, 1'b1); idle(6);

        // Continuous run, stop at phase 3 of period 7
        load_cfg(9, 5, 0);
        step(1'b0, 1'b1, 1'b0, 1'b1); idle(62);
        step(1'b0, 1'b0, 1'b1, 1'b1); idle(20);

        // Enable freeze in the high phase, stop latched while frozen
        load_cfg(7, 4, 2);
        step(1'b0, 1'b1, 1'b0, 1'b1); idle(2);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        idle(20);
        step(1'b0, 1'b1, 1'b0, 1'b1); idle(3);
        step(1'b0, 1'b0, 1'b1, 1'b0); step(1'b0, 1'b0, 1'b0, 1'b0);
        idle(12);
        // Start with enable low in IDLE is ignored
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);

        // Abort via load, then new config on next start; start while running ignored
        load_cfg(4, 2, 3);
        step(1'b0, 1'b1, 1'b0, 1'b1); idle(2);
        load_cfg(5, 3, 1);
        idle(2);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b0, 1'b1);
        idle(6);

        // Asynchronous reset mid-run
        load_cfg(6, 3, 0);
        step(1'b0, 1'b1, 1'b0, 1'b1); idle(3);
        async_reset();
        idle(2);

        // Width extremes: P=1024, H=512
        load_cfg(1023, 512, 2);
        step(1'b0, 1'b1, 1'b0, 1'b1); idle(2060);
        // Burst of 255 at minimum period
        load_cfg(0, 0, 255);
        step(1'b0, 1'b1, 1'b0, 1'b1); idle(520);
        // Continuous beyond 255 periods: count saturates
        load_cfg(1, 1, 0);
        step(1'b0, 1'b1, 1'b0, 1'b1); idle(600);
        step(1'b0, 1'b0, 1'b1, 1'b1); idle(5);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            bit l, s, sp, e_n;
            l   = ($urandom_range(0, 99) < 2);
            s   = ($urandom_range(0, 99) < 20);
            sp  = ($urandom_range(0, 99) < 3);
            e_n = ($urandom_range(0, 99) < 88);
            if (l) begin
                divc  = ($urandom_range(0, 9) == 0) ? DIV_W'($urandom_range(0, 1023))
                                                    : DIV_W'($urandom_range(0, 12));
                highc = DIV_W'($urandom_range(0, 15));
                burst = CNT_W'($urandom_range(0, 5));
            end
            step(l, s, sp, e_n);
        end
        idle(2);
        @(posedge clk);
        #4;
        chk("done_pulses_seen", 32'(n_done_seen > 5), 32'd1);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cal_pulse_gen.md
Name: cal_pulse_gen

Overview:
- Parametrised successor to the calibration clock divider.
- Generates a programmable calibration pulse train on cal_out from cal_clkin:
  - period and high time are set independently;
  - runs as a fixed-length burst or continuously, with graceful stop.
- Sits between the host/sequencer register interface and the calibration injection circuitry of the NMR front end.

Parameters:
DIV_W, 10, width of period and high-time fields (period up to 2^DIV_W cycles)
CNT_W, 8, width of burst length and period counter

Ports:
cal_clkin  in  1  system clock; all logic on rising edge
cal_reset  in  1  asynchronous, active-low reset
cal_en  in  1  count enable; low freezes all run state
cal_load  in  1  latch configuration inputs into shadow registers; aborts any run
cal_divcount  in  DIV_W  period minus one, in cycles
cal_highcount  in  DIV_W  high cycles per period
cal_burst  in  CNT_W  periods per burst; 0 = continuous
cal_start  in  1  start a run (level sampled, edge not required)
cal_stop  in  1  request stop at end of current period
cal_out  out  1  calibration pulse, registered
cal_busy  out  1  high while in RUN
cal_done  out  1  one-cycle pulse when a run ends normally
cal_pcount  out  CNT_W  completed periods in current/last run

Behaviour:
- Reset (cal_reset=0, async):
  - cal_out, cal_busy, cal_done and cal_pcount = 0; state IDLE.
  - Shadow values: P=2, H=1, B=0.
- Load (any state, highest priority):
  - Computes P = max(cal_divcount,1)+1, then H = cal_highcount clamped to [1, P-1], and B = cal_burst.
  - Phase counter cleared, stop request cleared, state goes to IDLE, cal_out=0, cal_busy=0.
  - No cal_done pulse; cal_pcount holds.
- States: IDLE, RUN.
- IDLE -> RUN when cal_start=1, cal_en=1 and cal_load=0 are all sampled on an edge.
  - On that same edge: phase=0, cal_pcount=0, cal_out=1, cal_busy=1.
  - Latency start->cal_out high is one edge.
- In RUN, with cal_en=1, on each edge:
  - phase advances and wraps at P-1.
  - cal_out=1 for phases 0..H-1 and 0 for phases H..P-1, so the period is exactly P cycles with exactly H high.
- Period wrap (phase==P-1 at an edge):
  - cal_pcount increments, saturating at 2^CNT_W-1.
  - The run ends if B!=0 and the new count == B, or if a stop request is pending.
  - Run end: state goes to IDLE, cal_out=0, cal_busy=0, cal_done=1 for one cycle.
  - Otherwise phase goes to 0 and cal_out=1.
- cal_stop:
  - Sampled in RUN, it sets a sticky stop request honoured at the next wrap.
  - If sampled on the wrap edge itself, it ends the run on that wrap.
  - Ignored in IDLE.
- cal_en=0:
  - In RUN: phase, cal_out, cal_pcount and the stop request hold. cal_stop is still latched.
  - In IDLE: cal_start is ignored.
- cal_start while RUN is ignored, with no restart.
- Simultaneous events:
  - cal_load beats cal_start, wrap and stop.
  - Burst-end and stop on the same wrap give a single cal_done.
- Arithmetic: P is computed in DIV_W+1 bits, so cal_divcount = 2^DIV_W-1 gives P = 2^DIV_W with no overflow.
- Minimum period is 2 cycles: divcount 0 or 1 gives P=2, H=1.
- Reset asserted mid-run clears everything immediately. No cal_done.

Test Plan:
- Burst:
  - Stimulus: load divcount=4, highcount=2, burst=3, then start.
  - Required: cal_out is 1,1,0,0,0 repeated 3 times, 15 cycles of busy.
  - cal_done is high 1 cycle as busy falls; cal_pcount=3 is held afterwards.
- Clamping:
  - Load divcount=0, highcount=0 -> P=2, H=1, so cal_out toggles 1,0.
  - Load divcount=3, highcount=9 -> H=3, giving pattern 1,1,1,0.
- Continuous with stop:
  - Stimulus: burst=0, divcount=9, highcount=5, start; assert cal_stop for 1 cycle at phase 3 of period 7.
  - Required: the run ends at the end of period 7, with cal_pcount=7 and one cal_done.
- Enable freeze:
  - Stimulus: deassert cal_en for 4 cycles mid high-phase.
  - Required: cal_out stays 1 and phase holds; the total period measured with enable is unchanged.
  - cal_start with cal_en=0 in IDLE does not start.
- Abort and reset:
  - cal_load at phase 2 of a burst -> cal_out=0 and busy=0 next edge, no cal_done, new config used on next start.
  - cal_reset low mid-run -> all outputs 0 asynchronously.
- Width extremes:
  - Stimulus: DIV_W=10, divcount=1023, highcount=512, burst=255.
  - Required: period 1024 cycles with 512 high; cal_pcount saturates correctly when burst=0 runs more than 255 periods.
